// File: rtl/instr_fetch_unit.sv
// Fetch stage: latches the PC, issues one instruction-memory request at a time,
// and hands {instr, pc, fault} to decode over a valid/ready handshake.
module instr_fetch_unit #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_en_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic [1:0]  if_fault_o,
    output logic        pc_advance_o,
    output logic        halted_o,
    output logic [2:0]  state_o
);

    // Handshakes: imem request is transferred on a cycle with imem_req_o & imem_gnt_i;
    // imem_req_o/imem_addr_o hold until then unless a flush withdraws them. Decode
    // transfer happens on if_valid_o & if_ready_i; outputs hold until then.

    localparam int unsigned   CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    localparam logic [1:0] F_NONE     = 2'b00;
    localparam logic [1:0] F_MISALIGN = 2'b01;
    localparam logic [1:0] F_TIMEOUT  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_DRAIN = 3'd4,
        S_HALT  = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [1:0]    fault_q, fault_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pc_advance;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            fault_q <= F_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
        pc_advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fetch_en_i && !flush_i) begin
                    pc_d = pc_i;
                    if (pc_i[1:0] != 2'b00) begin
                        instr_d = NOP_INSTR;
                        fault_d = F_MISALIGN;
                        state_d = S_OUT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (imem_gnt_i) begin
                    cnt_d   = '0;
                    state_d = flush_i ? S_DRAIN : S_WAIT;
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                // A flush never lets a response reach decode; an unanswered request must drain.
                if (flush_i) begin
                    state_d = imem_rvalid_i ? S_IDLE : S_DRAIN;
                end else if (imem_rvalid_i) begin
                    instr_d = imem_rdata_i;
                    fault_d = F_NONE;
                    state_d = S_OUT;
                end else if (cnt_q == CNT_LAST) begin
                    instr_d = NOP_INSTR;
                    fault_d = F_TIMEOUT;
                    state_d = S_OUT;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_OUT: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (if_ready_i) begin
                    pc_advance = 1'b1;
                    state_d    = (fault_q == F_TIMEOUT) ? S_HALT : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid_i) begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req_o   = (state_q == S_REQ);
    assign imem_addr_o  = pc_q;
    assign if_valid_o   = (state_q == S_OUT);
    assign if_instr_o   = instr_q;
    assign if_pc_o      = pc_q;
    assign if_fault_o   = fault_q;
    assign pc_advance_o = pc_advance;
    assign halted_o     = (state_q == S_HALT);
    assign state_o      = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: vector table, randomized fetches against a
// transaction-level model, and hand-written flush/reset/timeout sequences.
module tb_instr_fetch_unit;

    localparam int          T   = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] pc_in;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [1:0]  if_fault;
    logic        pc_advance;
    logic        halted;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;

    instr_fetch_unit #(.TIMEOUT_CYC(T), .NOP_INSTR(NOP)) dut (
        .clk_i(clk), .rst_i(rst), .fetch_en_i(fetch_en), .pc_i(pc_in), .flush_i(flush),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
        .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .if_valid_o(if_valid), .if_ready_i(if_ready), .if_instr_o(if_instr),
        .if_pc_o(if_pc), .if_fault_o(if_fault), .pc_advance_o(pc_advance),
        .halted_o(halted), .state_o(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (if_valid) valid_cnt <= valid_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] pc;
        int          g;
        int          r;
        logic [31:0] rdata;
        int          rdy;
        logic [31:0] e_instr;
        logic [1:0]  e_fault;
        int          e_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},    {31'd0, imem_req},   32'd0);
        chk({tag, "_addr"},   imem_addr,           32'd0);
        chk({tag, "_valid"},  {31'd0, if_valid},   32'd0);
        chk({tag, "_instr"},  if_instr,            32'd0);
        chk({tag, "_pc"},     if_pc,               32'd0);
        chk({tag, "_fault"},  {30'd0, if_fault},   32'd0);
        chk({tag, "_adv"},    {31'd0, pc_advance}, 32'd0);
        chk({tag, "_halted"}, {31'd0, halted},     32'd0);
        chk({tag, "_state"},  {29'd0, dbg_state},  32'd0);
    endtask

    // Transaction-level reference: what decode should see and how many cycles after
    // the latching IDLE cycle if_valid first appears (gnt after g, rvalid after r).
    function automatic void ref_fetch(input logic [31:0] pc, input int g, input int r,
                                      input logic [31:0] rdata, output logic [31:0] instr,
                                      output logic [1:0] fault, output int lat);
        if (pc % 4 != 0) begin
            instr = NOP; fault = 2'b01; lat = 1;
        end else if (r >= T) begin
            instr = NOP; fault = 2'b10; lat = 2 + g + T;
        end else begin
            instr = rdata; fault = 2'b00; lat = 3 + g + r;
        end
    endfunction

    // One full fetch from IDLE with a memory responder and a decode consumer.
    task automatic do_fetch(input logic [31:0] pc, input int g, input int r, input logic [31:0] rdata,
                            input int rdy, input logic [31:0] e_instr, input logic [1:0] e_fault,
                            input int e_lat, input string tag);
        int  i = 0;
        int  reqs = 0;
        int  wcnt = 0;
        bit  granted = 0;
        bit  done = 0;
        bit  addr_ok = 1;
        bit  stable = 1;
        @(negedge clk);
        fetch_en = 1'b1;
        pc_in    = pc;
        while (!done && i < 200) begin
            @(negedge clk);
            i++;
            fetch_en    = 1'b0;
            pc_in       = $urandom;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (if_valid) begin
                done = 1;
            end else begin
                if (granted) begin
                    if (wcnt == r) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = rdata;
                    end
                    wcnt++;
                end
                if (imem_req) begin
                    if (imem_addr !== pc) addr_ok = 0;
                    if (reqs == g) begin
                        imem_gnt = 1'b1;
                        granted  = 1;
                    end
                    reqs++;
                end
            end
        end
        if (!done) begin
            chk({tag, "_valid_wait"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, "_latency"}, i, e_lat);
        chk({tag, "_instr"}, if_instr, e_instr);
        chk({tag, "_pc"}, if_pc, pc);
        chk({tag, "_fault"}, {30'd0, if_fault}, {30'd0, e_fault});
        chk({tag, "_mem_used"}, {31'd0, reqs != 0}, {31'd0, e_fault != 2'b01});
        chk({tag, "_addr"}, {31'd0, addr_ok}, 32'd1);
        for (int k = 0; k < rdy; k++) begin
            #1;
            if (pc_advance !== 1'b0 || if_valid !== 1'b1 || if_instr !== e_instr ||
                if_pc !== pc || if_fault !== e_fault) stable = 0;
            @(negedge clk);
            imem_rdata = $urandom;
        end
        chk({tag, "_hold"}, {31'd0, stable}, 32'd1);
        if_ready = 1'b1;
        #1;
        chk({tag, "_pc_advance"}, {31'd0, pc_advance}, 32'd1);
        @(negedge clk);
        if_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, if_valid}, 32'd0);
        chk({tag, "_halted"}, {31'd0, halted}, {31'd0, e_fault == 2'b10});
    endtask

    task automatic start_fetch(input logic [31:0] pc);
        @(negedge clk);
        fetch_en = 1'b1;
        pc_in    = pc;
        @(negedge clk);
        fetch_en = 1'b0;
    endtask

    initial begin
        logic [31:0] e_instr;
        logic [1:0]  e_fault;
        int          e_lat;
        int          v0;
        bit          ok;

        vecs[0] = '{32'h0000_0100, 0, 0, 32'h0050_0093, 0, 32'h0050_0093, 2'b00, 3};
        vecs[1] = '{32'h0000_0102, 0, 0, 32'hAAAA_5555, 0, NOP,           2'b01, 1};
        vecs[2] = '{32'h0000_0101, 0, 0, 32'h1111_2222, 1, NOP,           2'b01, 1};
        vecs[3] = '{32'h0000_0103, 2, 2, 32'h3333_4444, 0, NOP,           2'b01, 1};
        vecs[4] = '{32'h0000_0104, 2, 3, 32'h1234_5678, 5, 32'h1234_5678, 2'b00, 8};
        vecs[5] = '{32'h0000_0108, 0, 7, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 2'b00, 10};
        vecs[6] = '{32'hFFFF_FFFC, 1, 0, 32'h0000_006F, 2, 32'h0000_006F, 2'b00, 4};
        vecs[7] = '{32'h0000_0000, 3, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 2'b00, 7};

        rst = 1'b1; fetch_en = 1'b0; pc_in = '0; flush = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        foreach (vecs[n])
            do_fetch(vecs[n].pc, vecs[n].g, vecs[n].r, vecs[n].rdata, vecs[n].rdy,
                     vecs[n].e_instr, vecs[n].e_fault, vecs[n].e_lat, $sformatf("vec%0d", n));

        for (int n = 0; n < 24; n++) begin
            logic [31:0] pc;
            logic [31:0] rd;
            int g, r, rdy;
            pc  = $urandom;
            if ($urandom_range(0, 4) != 0) pc[1:0] = 2'b00;
            g   = $urandom_range(0, 3);
            r   = $urandom_range(0, T - 1);
            rdy = $urandom_range(0, 3);
            rd  = $urandom;
            ref_fetch(pc, g, r, rd, e_instr, e_fault, e_lat);
            do_fetch(pc, g, r, rd, rdy, e_instr, e_fault, e_lat, $sformatf("rnd%0d", n));
        end

        // Flush in WAIT, late response must be drained and never reach decode.
        v0 = valid_cnt;
        start_fetch(32'h0000_0300);
        imem_gnt = 1'b1;
        @(negedge clk); imem_gnt = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        @(negedge clk); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk); imem_rvalid = 1'b0;
        chk("flush_wait_no_valid", valid_cnt - v0, 32'd0);
        do_fetch(32'h0000_0200, 0, 1, 32'h1111_1111, 0, 32'h1111_1111, 2'b00, 4, "after_drain");

        // Flush in REQ without gnt withdraws the request.
        start_fetch(32'h0000_0400);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("withdraw_req", {31'd0, imem_req}, 32'd0);
        chk("withdraw_valid", {31'd0, if_valid}, 32'd0);
        do_fetch(32'h0000_0404, 1, 0, 32'h0404_0404, 0, 32'h0404_0404, 2'b00, 4, "after_withdraw");

        // Flush together with gnt: unit drains and ignores fetch_en until rvalid.
        start_fetch(32'h0000_0500);
        flush = 1'b1; imem_gnt = 1'b1;
        @(negedge clk); flush = 1'b0; imem_gnt = 1'b0; fetch_en = 1'b1; pc_in = 32'h0000_0504;
        @(negedge clk); fetch_en = 1'b0;
        chk("drain_ignores_fetch", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk); imem_rvalid = 1'b0;
        chk("drain_no_valid", {31'd0, if_valid}, 32'd0);

        // Flush and rvalid in the same WAIT cycle returns straight to IDLE.
        start_fetch(32'h0000_0600);
        imem_gnt = 1'b1;
        @(negedge clk); imem_gnt = 1'b0; flush = 1'b1; imem_rvalid = 1'b1;
        @(negedge clk); flush = 1'b0; imem_rvalid = 1'b0; fetch_en = 1'b1; pc_in = 32'h0000_0604;
        @(negedge clk); fetch_en = 1'b0;
        chk("flush_rvalid_idle", {31'd0, imem_req}, 32'd1);
        chk("flush_rvalid_addr", imem_addr, 32'h0000_0604);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("flush_rvalid_withdraw", {31'd0, imem_req}, 32'd0);

        // Flush in OUT drops the word with no pc_advance even while if_ready is high.
        @(negedge clk); fetch_en = 1'b1; pc_in = 32'h0000_0106;
        @(negedge clk); fetch_en = 1'b0;
        chk("out_flush_valid", {31'd0, if_valid}, 32'd1);
        if_ready = 1'b1; flush = 1'b1;
        #1;
        chk("out_flush_no_adv", {31'd0, pc_advance}, 32'd0);
        @(negedge clk); if_ready = 1'b0; flush = 1'b0;
        chk("out_flush_dropped", {31'd0, if_valid}, 32'd0);

        // Asynchronous reset mid-WAIT clears everything without a clock edge.
        start_fetch(32'h0000_0700);
        imem_gnt = 1'b1;
        @(negedge clk); imem_gnt = 1'b0;
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        @(negedge clk); rst = 1'b0;

        // Timeout: fault exactly T cycles after gnt, then halt with no further requests.
        do_fetch(32'h0000_0800, 1, T, 32'h5555_5555, 2, NOP, 2'b10, 2 + 1 + T, "timeout");
        ok = 1;
        fetch_en = 1'b1; pc_in = 32'h0000_0900;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (imem_req !== 1'b0 || halted !== 1'b1 || if_valid !== 1'b0) ok = 0;
        end
        fetch_en = 1'b0;
        chk("halt_sticky", {31'd0, ok}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
